inv_permutate_buf: RTL

- Inverse-direction companion of the DCT2 1D output permutation stage.
- Accepts transform coefficients in natural order as a 4-lane stream.
- Buffers one block of 4/8/16/32 points and scatters it into the even/odd butterfly groups (X2E, X2O, X4O, X8O, X16O) consumed by the inverse partial-butterfly datapath.
- Valid/ready on both sides; one block buffered; back-to-back blocks supported.

---
 rtl/inv_permutate_buf_if.sv | 44 ++++
 rtl/inv_permutate_buf.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/inv_permutate_buf_if.sv
// Bus bundle for inv_permutate_buf: natural-order beat input side plus the
// butterfly-group block output side. The optional last/err pair is present
// only when INV_PERM_LAST_CHK_EN is defined.
interface inv_permutate_buf_if #(
   parameter int LANES = 4,
   parameter int DW    = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_n;
   logic [LANES*DW-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [1:0]            out_n;
   logic [2*DW-1:0]       X2E;
   logic [2*DW-1:0]       X2O;
   logic [4*DW-1:0]       X4O;
   logic [8*DW-1:0]       X8O;
   logic [16*DW-1:0]      X16O;
`ifdef INV_PERM_LAST_CHK_EN
   logic                  in_last;
   logic                  err;
`endif

   // upstream producer / downstream consumer side
   modport master (
`ifdef INV_PERM_LAST_CHK_EN
      output in_last,
      input  err,
`endif
      output in_valid, in_n, in_data, out_ready,
      input  in_ready, out_valid, out_n, X2E, X2O, X4O, X8O, X16O
   );

   // permutation buffer side
   modport slave (
`ifdef INV_PERM_LAST_CHK_EN
      input  in_last,
      output err,
`endif
      input  in_valid, in_n, in_data, out_ready,
      output in_ready, out_valid, out_n, X2E, X2O, X4O, X8O, X16O
   );
endinterface

// File: rtl/inv_permutate_buf.sv
// inv_permutate_buf: collects one 4/8/16/32-point block of natural-order
// coefficients (4 per beat) and scatters it into the X2E/X2O/X4O/X8O/X16O
// groups of the inverse partial butterfly. One block buffered; a new block's
// first beat may be taken in the same cycle the held block is handed off.
// Optional: INV_PERM_LAST_CHK_EN adds in_last framing check with sticky err.
module inv_permutate_buf #(
   parameter int LANES = 4,
   parameter int DW    = 16
) (
   input logic                clk,
   input logic                rst_n,
   inv_permutate_buf_if.slave bus
);
   typedef enum logic {FILL, FULL} state_t;

   state_t        state, state_next;
   logic [2:0]    cnt, cnt_next, last_cnt;
   logic [1:0]    n_eff, size_code;
   logic          ready, accept, first;
   logic [6:0]    m;
   logic [DW-1:0] d;

   logic [DW-1:0] x2e[2], x2o[2], x4o[4], x8o[8], x16o[16];
   logic [DW-1:0] x2e_next[2], x2o_next[2], x4o_next[4], x8o_next[8], x16o_next[16];

   // Destination of coefficient k for size code n, as {group, index}.
   // group 0 = X2E, otherwise group = log2 of the odd-group size (1..4).
   function automatic logic [6:0] map_k(input logic [4:0] k, input logic [1:0] n);
      logic [2:0] t;
      logic [4:0] half, idx;
      logic [2:0] lg;
      half = 5'd16 >> n;
      t    = 3'd0;
      for (int b = 4; b >= 0; b--)
         if (k[b]) t = 3'(b);
      idx = k >> (t + 3'd1);
      lg  = 3'd4 - {1'b0, n} - t;
      if (k == 5'd0)                    return {3'd0, 4'd0};
      else if (k == half)               return {3'd0, 4'd1};
      else if (n == 2'd3 && k == 5'd1)  return {3'd1, 4'd1};
      else if (n == 2'd3 && k == 5'd3)  return {3'd1, 4'd0};
      else                              return {lg, idx[3:0]};
   endfunction

   // in_ready depends only on state and out_ready, never on in_valid
   assign ready  = (state == FILL) | bus.out_ready;
   assign accept = bus.in_valid & ready;
   assign first  = (cnt == 3'd0);
   assign n_eff  = first ? bus.in_n : size_code;
   assign last_cnt = 3'd7 >> n_eff;

   // state / beat-counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FILL;
         cnt   <= 3'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // next state: a beat in FULL is always the first beat of the next block
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (accept) begin
         if (cnt == last_cnt) begin
            cnt_next   = 3'd0;
            state_next = FULL;
         end else begin
            cnt_next   = cnt + 3'd1;
            state_next = FILL;
         end
      end else if (state == FULL && bus.out_ready) begin
         state_next = FILL;
      end
   end

   // scatter the accepted beat; first beat starts from a cleared buffer
   always_comb begin
      x2e_next  = x2e;
      x2o_next  = x2o;
      x4o_next  = x4o;
      x8o_next  = x8o;
      x16o_next = x16o;
      m = '0;
      d = '0;
      if (accept) begin
         if (first) begin
            x2e_next  = '{default: '0};
            x2o_next  = '{default: '0};
            x4o_next  = '{default: '0};
            x8o_next  = '{default: '0};
            x16o_next = '{default: '0};
         end
         for (int j = 0; j < LANES; j++) begin
            m = map_k({cnt, j[1:0]}, n_eff);
            d = bus.in_data[j*DW +: DW];
            case (m[6:4])
               3'd0:    x2e_next[m[0]]    = d;
               3'd1:    x2o_next[m[0]]    = d;
               3'd2:    x4o_next[m[1:0]]  = d;
               3'd3:    x8o_next[m[2:0]]  = d;
               default: x16o_next[m[3:0]] = d;
            endcase
         end
      end
   end

   // group registers and held size code
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x2e       <= '{default: '0};
         x2o       <= '{default: '0};
         x4o       <= '{default: '0};
         x8o       <= '{default: '0};
         x16o      <= '{default: '0};
         size_code <= 2'd0;
      end else begin
         x2e  <= x2e_next;
         x2o  <= x2o_next;
         x4o  <= x4o_next;
         x8o  <= x8o_next;
         x16o <= x16o_next;
         if (accept && first) size_code <= bus.in_n;
      end
   end

`ifdef INV_PERM_LAST_CHK_EN
   logic err_flag;
   // sticky framing error: in_last must mark exactly the final beat
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_flag <= 1'b0;
      else if (accept && (bus.in_last != (cnt == last_cnt)))
         err_flag <= 1'b1;
   end
   assign bus.err = err_flag;
`endif

   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == FULL);
   assign bus.out_n     = size_code;

   // element 0 of every group sits in the most significant slot
   for (genvar i = 0; i < 2; i++) begin : g_pack2
      assign bus.X2E[(2-i)*DW-1 -: DW] = x2e[i];
      assign bus.X2O[(2-i)*DW-1 -: DW] = x2o[i];
   end
   for (genvar i = 0; i < 4; i++) begin : g_pack4
      assign bus.X4O[(4-i)*DW-1 -: DW] = x4o[i];
   end
   for (genvar i = 0; i < 8; i++) begin : g_pack8
      assign bus.X8O[(8-i)*DW-1 -: DW] = x8o[i];
   end
   for (genvar i = 0; i < 16; i++) begin : g_pack16
      assign bus.X16O[(16-i)*DW-1 -: DW] = x16o[i];
   end
endmodule
